// File: rtl/serial_subtracting.sv
// serial_subtracting: bit-serial two-lane unsigned subtractor.
//
// Computes diff1 = a - b and diff2 = c - d modulo 2^WIDTH, one bit per clock,
// LSB first, with one borrow flop per lane. A start accepted in idle latches all
// four operands. WIDTH clocks later a one-cycle done pulse marks the new results.
// The results and final borrows hold until the next completed operation.
//
// Ports:
//   clk        clock, rising-edge active
//   rst        asynchronous active-high reset
//   start_i    operation request, sampled only while idle
//   a_i, b_i   lane-1 minuend / subtrahend (latched on accepted start)
//   c_i, d_i   lane-2 minuend / subtrahend (latched on accepted start)
//   busy_o     high while bits are being processed
//   done_o     one-cycle completion pulse
//   diff1_o    a - b modulo 2^WIDTH
//   diff2_o    c - d modulo 2^WIDTH
//   borrow1_o  1 when a < b (unsigned)
//   borrow2_o  1 when c < d (unsigned)
module serial_subtracting #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff1_o,
    output logic [WIDTH-1:0] diff2_o,
    output logic             borrow1_o,
    output logic             borrow2_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Operand shift registers: consumed from bit 0, shifted right each RUN cycle.
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] c_sh_q, c_sh_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;

    // Result shift registers: each new bit enters at the MSB, so after WIDTH
    // shifts bit 0 of the difference has arrived at bit 0.
    logic [WIDTH-1:0] res1_q, res1_d;
    logic [WIDTH-1:0] res2_q, res2_d;

    // Per-lane running borrow.
    logic bin1_q, bin1_d;
    logic bin2_q, bin2_d;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Visible results, only updated on the final RUN edge.
    logic [WIDTH-1:0] diff1_q, diff1_d;
    logic [WIDTH-1:0] diff2_q, diff2_d;
    logic             borrow1_q, borrow1_d;
    logic             borrow2_q, borrow2_d;

    // Single-bit full subtractor per lane.
    logic x1, y1, dbit1, bout1;
    logic x2, y2, dbit2, bout2;

    always_comb begin
        x1    = a_sh_q[0];
        y1    = b_sh_q[0];
        dbit1 = x1 ^ y1 ^ bin1_q;
        bout1 = (~x1 & y1) | (~(x1 ^ y1) & bin1_q);

        x2    = c_sh_q[0];
        y2    = d_sh_q[0];
        dbit2 = x2 ^ y2 ^ bin2_q;
        bout2 = (~x2 & y2) | (~(x2 ^ y2) & bin2_q);
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        c_sh_d    = c_sh_q;
        d_sh_d    = d_sh_q;
        res1_d    = res1_q;
        res2_d    = res2_q;
        bin1_d    = bin1_q;
        bin2_d    = bin2_q;
        cnt_d     = cnt_q;
        diff1_d   = diff1_q;
        diff2_d   = diff2_q;
        borrow1_d = borrow1_q;
        borrow2_d = borrow2_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    c_sh_d  = c_i;
                    d_sh_d  = d_i;
                    bin1_d  = 1'b0;
                    bin2_d  = 1'b0;
                    cnt_d   = '0;
                end
            end

            StRun: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                c_sh_d = c_sh_q >> 1;
                d_sh_d = d_sh_q >> 1;
                res1_d = {dbit1, res1_q[WIDTH-1:1]};
                res2_d = {dbit2, res2_q[WIDTH-1:1]};
                bin1_d = bout1;
                bin2_d = bout2;

                if (cnt_q == LastBit) begin
                    // Publish the completed words directly from the shift input
                    // so the final bit is included on this same edge.
                    state_d   = StDone;
                    diff1_d   = {dbit1, res1_q[WIDTH-1:1]};
                    diff2_d   = {dbit2, res2_q[WIDTH-1:1]};
                    borrow1_d = bout1;
                    borrow2_d = bout2;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            c_sh_q    <= '0;
            d_sh_q    <= '0;
            res1_q    <= '0;
            res2_q    <= '0;
            bin1_q    <= 1'b0;
            bin2_q    <= 1'b0;
            cnt_q     <= '0;
            diff1_q   <= '0;
            diff2_q   <= '0;
            borrow1_q <= 1'b0;
            borrow2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            c_sh_q    <= c_sh_d;
            d_sh_q    <= d_sh_d;
            res1_q    <= res1_d;
            res2_q    <= res2_d;
            bin1_q    <= bin1_d;
            bin2_q    <= bin2_d;
            cnt_q     <= cnt_d;
            diff1_q   <= diff1_d;
            diff2_q   <= diff2_d;
            borrow1_q <= borrow1_d;
            borrow2_q <= borrow2_d;
        end
    end

    always_comb begin
        busy_o    = (state_q == StRun);
        done_o    = (state_q == StDone);
        diff1_o   = diff1_q;
        diff2_o   = diff2_q;
        borrow1_o = borrow1_q;
        borrow2_o = borrow2_q;
    end

endmodule

// File: tb/tb_serial_subtracting.sv
// tb_serial_subtracting: self-checking bench for serial_subtracting.
// Three instances (WIDTH = 2, 8, 16) share one operand bus and reset; each has
// its own start. Expected results come from plain modular arithmetic.
module tb_serial_subtracting;

    logic        clk;
    logic        rst;
    logic        st2, st8, st16;
    logic [15:0] a_v, b_v, c_v, d_v;

    logic        busy2, done2, br1_2, br2_2;
    logic [1:0]  d1_2, d2_2;
    logic        busy8, done8, br1_8, br2_8;
    logic [7:0]  d1_8, d2_8;
    logic        busy16, done16, br1_16, br2_16;
    logic [15:0] d1_16, d2_16;

    int n_total;
    int n_bad;

    // Last expected results per width, used to check that outputs hold.
    logic [15:0] prev_d1 [17];
    logic [15:0] prev_d2 [17];
    logic        prev_b1 [17];
    logic        prev_b2 [17];

    int          sel;
    logic        obs_busy, obs_done, obs_b1, obs_b2;
    logic [15:0] obs_d1, obs_d2;

    serial_subtracting #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .start_i(st2),
        .a_i(a_v[1:0]), .b_i(b_v[1:0]), .c_i(c_v[1:0]), .d_i(d_v[1:0]),
        .busy_o(busy2), .done_o(done2), .diff1_o(d1_2), .diff2_o(d2_2),
        .borrow1_o(br1_2), .borrow2_o(br2_2)
    );

    serial_subtracting #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start_i(st8),
        .a_i(a_v[7:0]), .b_i(b_v[7:0]), .c_i(c_v[7:0]), .d_i(d_v[7:0]),
        .busy_o(busy8), .done_o(done8), .diff1_o(d1_8), .diff2_o(d2_8),
        .borrow1_o(br1_8), .borrow2_o(br2_8)
    );

    serial_subtracting #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .start_i(st16),
        .a_i(a_v), .b_i(b_v), .c_i(c_v), .d_i(d_v),
        .busy_o(busy16), .done_o(done16), .diff1_o(d1_16), .diff2_o(d2_16),
        .borrow1_o(br1_16), .borrow2_o(br2_16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        obs_busy = busy8;
        obs_done = done8;
        obs_d1   = {8'h00, d1_8};
        obs_d2   = {8'h00, d2_8};
        obs_b1   = br1_8;
        obs_b2   = br2_8;
        if (sel == 2) begin
            obs_busy = busy2;
            obs_done = done2;
            obs_d1   = {14'h0, d1_2};
            obs_d2   = {14'h0, d2_2};
            obs_b1   = br1_2;
            obs_b2   = br2_2;
        end else if (sel == 16) begin
            obs_busy = busy16;
            obs_done = done16;
            obs_d1   = d1_16;
            obs_d2   = d2_16;
            obs_b1   = br1_16;
            obs_b2   = br2_16;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_start(input int w, input logic v);
        st2  = (w == 2)  ? v : 1'b0;
        st8  = (w == 8)  ? v : 1'b0;
        st16 = (w == 16) ? v : 1'b0;
    endtask

    function automatic logic [15:0] width_mask(input int w);
        logic [16:0] one;
        one = 17'd1;
        return 16'((one << w) - 17'd1);
    endfunction

    // One complete operation on the instance of width w, fully checked.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
        logic [15:0] m, ea, eb, ec, ed, e1, e2;
        logic        eb1, eb2;
        int          busy_n;
        bit          seen;
        m  = width_mask(w);
        ea = a & m;
        eb = b & m;
        ec = c & m;
        ed = d & m;
        e1 = (ea - eb) & m;
        e2 = (ec - ed) & m;
        eb1 = (ea < eb);
        eb2 = (ec < ed);
        sel = w;

        @(negedge clk);
        a_v = a; b_v = b; c_v = c; d_v = d;
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        // Operands change after acceptance; they must not matter.
        a_v = 16'($urandom); b_v = 16'($urandom); c_v = 16'($urandom); d_v = 16'($urandom);
        check_eq("hold_diff1", 32'(obs_d1), 32'(prev_d1[w]));
        check_eq("hold_diff2", 32'(obs_d2), 32'(prev_d2[w]));
        check_eq("hold_borrow1", 32'(obs_b1), 32'(prev_b1[w]));
        check_eq("hold_borrow2", 32'(obs_b2), 32'(prev_b2[w]));

        busy_n = 0;
        seen   = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (obs_done) begin
                seen = 1'b1;
            end else begin
                if (obs_busy) busy_n++;
                @(negedge clk);
            end
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("busy_cycles", 32'(busy_n), 32'(w));
        check_eq("busy_at_done", 32'(obs_busy), 32'd0);
        check_eq("diff1", 32'(obs_d1), 32'(e1));
        check_eq("diff2", 32'(obs_d2), 32'(e2));
        check_eq("borrow1", 32'(obs_b1), 32'(eb1));
        check_eq("borrow2", 32'(obs_b2), 32'(eb2));
        @(negedge clk);
        check_eq("done_pulse_one_cycle", 32'(obs_done), 32'd0);
        prev_d1[w] = e1;
        prev_d2[w] = e2;
        prev_b1[w] = eb1;
        prev_b2[w] = eb2;
    endtask

    // start held high with operands changing every cycle on the WIDTH=8 unit.
    task automatic run_stream();
        logic [7:0] qa [50];
        logic [7:0] qb [50];
        logic [7:0] qc [50];
        logic [7:0] qd [50];
        logic [7:0] e1, e2;
        int j;
        sel = 8;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_eq("stream_done", 32'(obs_done), 32'((i % 10) == 9));
            if ((i % 10) == 9) begin
                j  = i - 9;
                e1 = qa[j] - qb[j];
                e2 = qc[j] - qd[j];
                check_eq("stream_diff1", 32'(obs_d1), 32'(e1));
                check_eq("stream_diff2", 32'(obs_d2), 32'(e2));
                check_eq("stream_borrow1", 32'(obs_b1), 32'(qa[j] < qb[j]));
                check_eq("stream_borrow2", 32'(obs_b2), 32'(qc[j] < qd[j]));
                prev_d1[8] = {8'h00, e1};
                prev_d2[8] = {8'h00, e2};
                prev_b1[8] = (qa[j] < qb[j]);
                prev_b2[8] = (qc[j] < qd[j]);
            end
            qa[i] = 8'($urandom); qb[i] = 8'($urandom);
            qc[i] = 8'($urandom); qd[i] = 8'($urandom);
            a_v = {8'h00, qa[i]}; b_v = {8'h00, qb[i]};
            c_v = {8'h00, qc[i]}; d_v = {8'h00, qd[i]};
            set_start(8, 1'b1);
        end
        @(negedge clk);
        set_start(8, 1'b0);
    endtask

    initial begin
        int no_done;
        n_total = 0;
        n_bad   = 0;
        sel     = 8;
        for (int i = 0; i < 17; i++) begin
            prev_d1[i] = '0; prev_d2[i] = '0; prev_b1[i] = 1'b0; prev_b2[i] = 1'b0;
        end
        a_v = '0; b_v = '0; c_v = '0; d_v = '0;
        set_start(0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state of every instance.
        check_eq("rst_busy", 32'({busy2, busy8, busy16}), 32'd0);
        check_eq("rst_done", 32'({done2, done8, done16}), 32'd0);
        check_eq("rst_diff", 32'({d1_2, d2_2, d1_8, d2_8}), 32'd0);
        check_eq("rst_diff16", 32'({d1_16, d2_16}), 32'd0);
        check_eq("rst_borrow", 32'({br1_2, br2_2, br1_8, br2_8, br1_16, br2_16}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed WIDTH=8 cases.
        run_op(8, 16'd5, 16'd3, 16'd3, 16'd5);
        run_op(8, 16'h00, 16'hFF, 16'hFF, 16'h00);
        run_op(8, 16'hA5, 16'hA5, 16'h00, 16'h00);

        run_stream();
        repeat (12) @(negedge clk);

        // Reset in the middle of an operation.
        sel = 8;
        a_v = 16'h80; b_v = 16'h01; c_v = 16'h33; d_v = 16'h11;
        set_start(8, 1'b1);
        @(negedge clk);
        set_start(8, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("pre_rst_busy", 32'(busy8), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_busy", 32'(busy8), 32'd0);
        check_eq("async_rst_done", 32'(done8), 32'd0);
        check_eq("async_rst_diffs", 32'({d1_8, d2_8}), 32'd0);
        check_eq("async_rst_borrows", 32'({br1_8, br2_8}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            prev_d1[i] = '0; prev_d2[i] = '0; prev_b1[i] = 1'b0; prev_b2[i] = 1'b0;
        end
        no_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) no_done++;
        end
        check_eq("no_done_after_abort", 32'(no_done), 32'd0);
        run_op(8, 16'h80, 16'h01, 16'h33, 16'h11);

        // Randomised sweeps.
        for (int i = 0; i < 1000; i++)
            run_op(8, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        for (int i = 0; i < 100; i++)
            run_op(2, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        run_op(16, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000);
        for (int i = 0; i < 100; i++)
            run_op(16, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_subtracting.md
Name:
serial_subtracting

Overview:
- Bit-serial two-lane subtractor; the inverse counterpart of the team's combinational two-lane adding block.
- Computes diff1 = a - b and diff2 = c - d, LSB-first, one bit per clock, with a borrow flip-flop per lane.
- Start/busy/done handshake; results and final borrows are held until the next completed operation.
- Sits beside the adding block in the function test set and exercises sequential control around the same arithmetic.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE
a  input  WIDTH  lane-1 minuend, latched on accepted start
b  input  WIDTH  lane-1 subtrahend, latched on accepted start
c  input  WIDTH  lane-2 minuend, latched on accepted start
d  input  WIDTH  lane-2 subtrahend, latched on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle completion pulse
diff1  output  WIDTH  a - b modulo 2^WIDTH
diff2  output  WIDTH  c - d modulo 2^WIDTH
borrow1  output  1  1 when a < b (unsigned)
borrow2  output  1  1 when c < d (unsigned)

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, done=0, diff1=diff2=0, borrow1=borrow2=0; internal shift registers, borrow flops and bit counter are all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN:
  - on an edge with start=1;
  - latch a, b, c, d into shift registers; clear both borrow flops; counter=0; busy=1.
- RUN, each edge, per lane, with x and y the current LSBs and bin the lane's borrow flop:
  - dbit = x ^ y ^ bin
  - bout = (~x & y) | (~(x ^ y) & bin)
  - shift dbit into the MSB of the lane's result shift register (right shift); shift the operand registers right; borrow flop <= bout; counter++.
- RUN -> DONE on the edge that processes bit WIDTH-1:
  - same edge: diff1/diff2 <= final result registers, borrow1/borrow2 <= final bout, busy=0, done=1.
- DONE -> IDLE on the next edge; done=0.
- Latency: if start is sampled at edge E, done is high for exactly the cycle after edge E+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start is ignored in RUN and in DONE; no queuing; operands are not resampled.
- diff*/borrow* change only on the RUN->DONE edge and reset. They hold their values through later IDLE and RUN periods.
- Operand inputs may change freely after the accepting edge with no effect on the result.
- Arithmetic is unsigned, modulo 2^WIDTH. Equal operands give 0 with borrow 0. Both lanes run in lockstep, are fully independent, and finish on the same edge.
- Reset mid-operation aborts immediately: all state and outputs return to reset values and no done is produced. The first start after reset release begins a fresh operation.
- The counter is sized ceil(log2(WIDTH)) bits; it does not wrap within an operation.

Test Plan:
- WIDTH=8, a=5, b=3, c=3, d=5, start one cycle -> done after 8 edges; diff1=0x02, borrow1=0, diff2=0xFE, borrow2=1; busy high exactly 8 cycles.
- a=0x00, b=0xFF, c=0xFF, d=0x00 -> diff1=0x01, borrow1=1; diff2=0xFF, borrow2=0.
- a=b=0xA5, c=d=0x00 -> diff1=0x00, diff2=0x00, both borrows 0; previous results held until this done edge.
- start held high continuously with operands changed every cycle -> accepted only in IDLE (every 10 cycles); each result matches the operands present at its accepting edge; done is a single-cycle pulse each time.
- Assert rst at bit 4 of an operation with a=0x80, b=0x01 -> all outputs 0 immediately (asynchronous); no done; a new start after release gives diff1=0x7F, borrow1=0.
- Randomised sweep of 1000 operand sets checked against (x - y) mod 256 and (x < y); also run with WIDTH=2 and WIDTH=16 to cover counter sizing.
